// File: rtl/imem_loader.sv
// Boot loader: takes a length-prefixed byte stream, writes it into imem from
// address 0, and keeps the processor in reset until the payload is complete.
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [7:0]            in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  restart_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [7:0]            mem_wdata_o,
    output logic                  cpu_reset_o,
    output logic                  done_o,
    output logic                  error_o
);
    // state   | meaning
    // LEN_HI  | waiting for length header high byte
    // LEN_LO  | waiting for length header low byte, then decode
    // LOAD    | writing payload bytes to imem
    // FLUSH   | last write presented, processor still in reset
    // RUN     | program loaded, processor released
    // ERROR   | bad header, sticky until restart or reset
    typedef enum logic [2:0] {
        S_LEN_HI, S_LEN_LO, S_LOAD, S_FLUSH, S_RUN, S_ERROR
    } state_e;

    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);

    state_e                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  xfer;
    logic [15:0]           len_full;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_LEN_HI;
            len_q       <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        xfer     = in_valid_i && ready_q;
        len_full = {len_q[15:8], in_data_i};

        case (state_q)
            S_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = in_data_i;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d = len_full;
                    cnt_d = '0;
                    if (({1'b0, len_full} > DEPTH) || (len_full[1:0] != 2'b00))
                        state_d = S_ERROR;
                    else if (len_full == 16'd0)
                        state_d = S_FLUSH;
                    else
                        state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[ADDR_WIDTH-1:0];
                    wdata_d = in_data_i;
                    cnt_d   = cnt_q + 1'b1;
                    if (16'(cnt_q) == len_q - 16'd1)
                        state_d = S_FLUSH;
                end
            end
            S_FLUSH: state_d = S_RUN;
            S_RUN, S_ERROR: begin
                if (restart_i)
                    state_d = S_LEN_HI;
            end
            default: state_d = S_LEN_HI;
        endcase

        // Status outputs follow the next state so they are registered with it.
        ready_d     = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) || (state_d == S_LOAD);
        cpu_reset_d = (state_d != S_RUN);
        done_d      = (state_d == S_RUN);
        error_d     = (state_d == S_ERROR);
    end

    assign in_ready_o  = ready_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign cpu_reset_o = cpu_reset_q;
    assign done_o      = done_q;
    assign error_o     = error_q;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a driver pushes expected imem writes into a queue and
// a negedge monitor pops and compares them whenever mem_we is seen.
module tb_imem_loader;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       restart;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_reset;
    logic       done;
    logic       error;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(8)) dut (
        .clk_i(clk), .reset_i(reset), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .restart_i(restart), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .cpu_reset_o(cpu_reset),
        .done_o(done), .error_o(error)
    );

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset && mem_we) begin
            logic [15:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} != e) begin
                    failures++;
                    $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                             mem_addr, mem_wdata, e[15:8], e[7:0]);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [7:0] b, input bit gap);
        int t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("ready_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic send_load(input logic [7:0] data[], input bit gap);
        send(8'(data.size() >> 8), gap);
        send(8'(data.size()), gap);
        for (int i = 0; i < data.size(); i++) begin
            exp_q.push_back({8'(i), data[i]});
            send(data[i], (i == data.size() - 1) ? 1'b0 : gap);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ready_first_cycle", in_ready, 0);
        @(negedge clk);
    endtask

    task automatic check_done(input string tag);
        chk({tag, "_flush_cpu_reset"}, cpu_reset, 1);
        chk({tag, "_flush_done"}, done, 0);
        chk({tag, "_flush_ready"}, in_ready, 0);
        @(negedge clk);
        chk({tag, "_run_cpu_reset"}, cpu_reset, 0);
        chk({tag, "_run_done"}, done, 1);
        chk({tag, "_run_ready"}, in_ready, 0);
        chk({tag, "_queue_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] prog[] = '{8'h20, 8'h08, 8'hFE, 8'hFE, 8'hAD, 8'h08, 8'h00, 8'h00};
        logic [7:0] p4a[]  = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] p4b[]  = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
        logic [7:0] full[];
        reset = 1'b1; in_data = 8'h00; in_valid = 1'b0; restart = 1'b0;
        #12;
        chk("rst_ready", in_ready, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        do_reset();
        chk("ready_after_reset", in_ready, 1);

        // Basic back-to-back load
        send_load(prog, 1'b0);
        check_done("basic");
        repeat (2) @(negedge clk);
        chk("basic_run_hold_done", done, 1);

        // Gapped stream
        do_reset();
        send_load(prog, 1'b1);
        check_done("gapped");

        // Zero length
        do_reset();
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        check_done("zero");

        // Bad headers: 257 and non-multiple-of-4
        do_reset();
        send(8'h01, 1'b0);
        send(8'h01, 1'b0);
        in_valid = 1'b1; in_data = 8'h77;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("bad257_error", error, 1);
        chk("bad257_cpu_reset", cpu_reset, 1);
        chk("bad257_ready", in_ready, 0);
        do_reset();
        send(8'h00, 1'b0);
        send(8'h06, 1'b0);
        in_valid = 1'b1; in_data = 8'h66;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("bad6_error", error, 1);
        chk("bad6_cpu_reset", cpu_reset, 1);
        chk("bad6_ready", in_ready, 0);
        chk("bad6_done", done, 0);

        // Full capacity
        do_reset();
        chk("error_cleared_by_reset", error, 0);
        full = new[256];
        for (int i = 0; i < 256; i++) full[i] = 8'(i * 7 + 3);
        send_load(full, 1'b0);
        chk("full_last_addr", mem_addr, 8'hFF);
        check_done("full");

        // Reset mid-load, then a fresh load, then restart
        do_reset();
        send(8'h00, 1'b0);
        send(8'h08, 1'b0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({8'(i), prog[i]});
            send(prog[i], 1'b0);
        end
        #2 reset = 1'b1;
        #1;
        chk("midrst_cpu_reset", cpu_reset, 1);
        chk("midrst_ready", in_ready, 0);
        chk("midrst_we", mem_we, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_load(p4a, 1'b0);
        check_done("after_midrst");
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("restart_done", done, 0);
        chk("restart_cpu_reset", cpu_reset, 1);
        chk("restart_error", error, 0);
        send_load(p4b, 1'b0);
        check_done("restart");

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
